// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary serializer.
package unary_pkg;

  typedef enum logic [0:0] {IDLE, SEND} unary_state_e;

  function automatic int unsigned sat_count(input int unsigned count, input int unsigned width);
    return (count > width) ? width : count;
  endfunction

endpackage

// File: rtl/unary_bit_counter.sv
// Frame bit index counter with synchronous clear/enable and a last-bit flag.
module unary_bit_counter #(
  parameter int unsigned width_p = 32,
  parameter int unsigned idx_w_p = $clog2(width_p)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [idx_w_p-1:0] o_idx,
  output logic               o_at_last
);

  logic [idx_w_p-1:0] r_idx;

  // Clear wins over enable so a back-to-back accept restarts at bit 0.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_idx     = r_idx;
  assign o_at_last = (r_idx == idx_w_p'(width_p - 1));

endmodule

// File: rtl/unary_serializer.sv
// Emits a width_p-bit frame holding count_i ones (ones first) over a valid/ready stream.
// Optional UNARY_SERIALIZER_B2B_EN lets a new count be accepted on the last beat.
module unary_serializer
  import unary_pkg::*;
#(
  parameter int unsigned width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [$clog2(width_p):0] count_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     last_o
);

  localparam int unsigned IdxW = $clog2(width_p);
  localparam int unsigned CntW = IdxW + 1;

  unary_state_e    r_state;
  logic [CntW-1:0] r_count;

  logic            w_accept;
  logic            w_beat;
  logic            w_at_last;
  logic [IdxW-1:0] w_idx;
  logic [CntW-1:0] w_sat;

  assign w_sat    = CntW'(sat_count(32'(count_i), width_p));
  assign w_accept = valid_i && ready_o;
  assign w_beat   = valid_o && ready_i;

  unary_bit_counter #(
    .width_p (width_p),
    .idx_w_p (IdxW)
  ) u_idx (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .i_clr     (w_accept),
    .i_en      (w_beat),
    .o_idx     (w_idx),
    .o_at_last (w_at_last)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= SEND;
            r_count <= w_sat;
          end
        end
        SEND: begin
          if (w_beat && w_at_last) begin
            if (w_accept) begin
              r_count <= w_sat;
            end else begin
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

`ifdef UNARY_SERIALIZER_B2B_EN
  assign ready_o = (r_state == IDLE) || ((r_state == SEND) && w_at_last && ready_i);
`else
  assign ready_o = (r_state == IDLE);
`endif

  assign valid_o = (r_state == SEND);
  assign data_o  = (r_state == SEND) && ({1'b0, w_idx} < r_count);
  assign last_o  = (r_state == SEND) && w_at_last;

endmodule

// File: doc/unary_serializer.md
Name: unary_serializer

Overview:
- Transmit-side counterpart of the popcount block: takes a count value and emits a serial frame of width_p bits containing exactly that many ones, ones first, then zeros.
- Lets a downstream popcount/accumulator be driven from a known count, and lets benches round-trip count -> bits -> countones.
- Valid/ready handshake on both sides; one bit per accepted output beat.

Parameters:
- width_p, 32, frame length in bits and maximum encodable count (must be >= 2).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- reset_ni  input  1  reset, synchronous and active-low.
- count_i  input  $clog2(width_p)+1  requested number of ones in the frame.
- valid_i  input  1  count_i valid.
- ready_o  output  1  block can accept a count this cycle.
- data_o  output  1  current serial bit.
- valid_o  output  1  data_o valid.
- ready_i  input  1  downstream accepts data_o this cycle.
- last_o  output  1  data_o is bit width_p-1 of the frame.

Behaviour:
- Reset (reset_ni=0 at a rising edge): state IDLE; ready_o=1, valid_o=0, data_o=0, last_o=0; internal counters cleared. Reset mid-frame aborts the frame immediately. No partial bits follow.
- Input handshake: a count is accepted when valid_i && ready_o at a rising edge.
- Saturation: if count_i > width_p, the latched value is width_p. For width_p=32, inputs 33..63 act as 32.
- FSM has two states, IDLE and SEND.
- IDLE: ready_o=1, valid_o=0. On accept, latch the count, clear bit index idx to 0, and go to SEND.
- SEND: ready_o=0 (base build), valid_o=1. data_o=1 iff idx < latched count. last_o=1 iff idx == width_p-1.
- Beat transfer: on valid_o && ready_i, idx increments. If last_o was set, return to IDLE.
- Backpressure: while ready_i=0, data_o, last_o and idx hold stable. valid_o never drops mid-frame.
- Latency: count accepted at edge N, so bit 0 is presented in the cycle after edge N. A frame takes exactly width_p transferred beats.
- count=0 gives an all-zero frame. count=width_p gives an all-ones frame.
- Outputs are registered or derived only from registered state plus compare. There is no combinational path from valid_i/ready_i to valid_o/ready_o in the base build.
- Invariant: the sum of data_o over the beats of one frame equals the saturated count. The bench checks this with countones.

Optional Feature:
- Macro: UNARY_SERIALIZER_B2B_EN.
- Defined: ready_o is also 1 in SEND while last_o && ready_i, which allows back-to-back frames. A count accepted on the last beat's edge starts the new frame with idx=0 in the next cycle, with no IDLE bubble and valid_o staying 1. This adds a combinational ready_i -> ready_o path.
- Undefined: at least one IDLE cycle (valid_o=0) separates frames.

Decomposition:
- Shared package unary_pkg holds:
  - typedef enum logic [0:0] {IDLE, SEND} unary_state_e;
  - function sat_count(count, width) used for saturation.
- One natural sub-module, unary_bit_counter: a $clog2(width_p)-bit up-counter with clear, enable and an at_last flag. It is instanced once for idx.

Test Plan:
- Reset: hold reset_ni=0 for 3 cycles -> ready_o=1, valid_o=0, last_o=0, data_o=0.
- count_i=5, ready_i=1 always -> 32 beats: bits 0..4 =1, bits 5..31 =0; last_o only on beat 31; countones of the collected frame = 5; ready_o returns to 1 the cycle after the last beat.
- count_i=0, then count_i=32, then count_i=45 -> frames with 0 ones, all ones, and all ones (saturated); countones = 0, 32, 32.
- count_i=20 with ready_i toggling 1,0,0,1 pattern -> data_o/last_o stable while stalled; exactly 32 transfers; 20 ones total.
- Drive reset_ni=0 at beat 10 of a count=31 frame -> next cycle valid_o=0, ready_o=1. A new count_i=3 then yields a clean frame with 3 ones.
- With UNARY_SERIALIZER_B2B_EN: counts 7 and 9 queued back-to-back -> 64 consecutive valid beats with no gap; per-frame counts 7 and 9. Without the macro, exactly one gap cycle between the frames.
